// File: rtl/det_pkg.sv
// Shared types and helpers for the round-robin "1101" detector arbiter.
`default_nettype none

package det_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} ctrl_state_t;
  typedef enum logic [1:0] {A, B, C, D} det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

  // Overlapping detector walk: each state records the longest matched prefix of PATTERN.
  function automatic det_state_t det_next(input det_state_t s, input logic b);
    det_state_t n;
    n = A;
    case (s)
      A:       n = b ? B : A;
      B:       n = b ? C : A;
      C:       n = b ? C : D;
      D:       n = b ? B : A;
      default: n = A;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq1101_det.sv
// Serial overlapping "1101" detector with synchronous clear and registered match flag.
`default_nettype none

module seq1101_det
  import det_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic i,
  output logic o
);

  det_state_t state_q, state_d;
  logic       o_q, o_d;

  always_comb begin
    state_d = det_next(state_q, i);
    o_d     = (state_q == D) && (i == PATTERN[0]);
    if (clr) begin
      state_d = A;
      o_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= A;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
    end
  end

  assign o = o_q;

endmodule

`default_nettype wire

// File: rtl/det_arbiter.sv
// Round-robin arbiter sharing one serial "1101" detector between two word requesters.
`default_nettype none

module det_arbiter
  import det_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              res_valid,
  output logic              res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy
);

  localparam int BCNT_W = $clog2(DATA_W);
  localparam logic [BCNT_W-1:0] FIRST_BIT = BCNT_W'(DATA_W - 1);

  ctrl_state_t       state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              id_q, id_d;
  logic              last_q, last_d;

  logic       grant;
  logic [1:0] ready_d;
  logic       det_clr;
  logic       det_o;

  seq1101_det u_det (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (det_clr),
    .i     (sreg_q[DATA_W-1]),
    .o     (det_o)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bcnt_d    = bcnt_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    grant     = 1'b0;
    ready_d   = 2'b00;
    det_clr   = 1'b0;
    res_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // On a tie the requester not served last wins.
          grant   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
          ready_d = 2'b01 << grant;
          sreg_d  = grant ? req_data1 : req_data0;
          id_d    = grant;
          last_d  = grant;
          cnt_d   = '0;
          bcnt_d  = FIRST_BIT;
          det_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        // Detector output in the first shift cycle still reflects the clear, not a word bit.
        if (bcnt_q != FIRST_BIT) cnt_d = cnt_q + CNT_W'(det_o);
        if (bcnt_q == '0) state_d = FLUSH;
        else              bcnt_d  = bcnt_q - 1'b1;
      end
      FLUSH: begin
        cnt_d   = cnt_q + CNT_W'(det_o);
        state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // The Mealy grant must stay silent while reset holds the FSM in IDLE.
  assign req_ready = ready_d & {2{n_rst}};
  assign res_id    = id_q;
  assign res_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_det_arbiter.sv
// Self-checking bench for det_arbiter: directed and random words against a string-scan reference.
`default_nettype none

module tb_det_arbiter;

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  logic              clk       = 1'b0;
  logic              n_rst     = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [DATA_W-1:0] req_data0 = '0;
  logic [DATA_W-1:0] req_data1 = '0;
  logic [1:0]        req_ready;
  logic              res_valid;
  logic              res_id;
  logic [CNT_W-1:0]  res_count;
  logic              busy;

  int   checks = 0;
  int   errors = 0;
  logic m_last = 1'b1;

  det_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_count (res_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count every 4-bit window of the word, MSB first, equal to 1101.
  function automatic int ref_count(input logic [DATA_W-1:0] w);
    int n;
    n = 0;
    for (int k = 0; k <= DATA_W - 4; k++)
      if (w[DATA_W-1-k -: 4] == 4'b1101) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_word(input logic [1:0] v, input logic [DATA_W-1:0] d0,
                            input logic [DATA_W-1:0] d1, output logic g, output int exp);
    int waited;
    waited    = 0;
    req_valid = v;
    req_data0 = d0;
    req_data1 = d1;
    #1;
    while (req_ready == 2'b00 && waited < 30) begin
      tick();
      #1;
      waited++;
    end
    if (waited >= 30) check("ready_timeout", 32'd1, 32'd0);
    g = (v == 2'b11) ? ~m_last : v[1];
    check("grant", 32'(req_ready), 32'(2'b01 << g));
    check("busy_accept", 32'(busy), 32'd0);
    m_last = g;
    exp    = ref_count(g ? d1 : d0);
    tick();
  endtask

  task automatic finish_word(input logic g, input int exp, input logic hold);
    if (!hold) req_valid = 2'b00;
    for (int c = 1; c <= DATA_W + 1; c++) begin
      #1;
      check("in_flight", 32'({busy, res_valid, req_ready}), 32'(4'b1000));
      tick();
    end
    #1;
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_id", 32'(res_id), 32'(g));
    check("res_count", 32'(res_count), 32'(exp));
    check("busy_done", 32'(busy), 32'd1);
    tick();
    #1;
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("res_count_hold", 32'(res_count), 32'(exp));
  endtask

  initial begin
    logic              g;
    int                exp;
    logic [1:0]        v;
    logic [DATA_W-1:0] d0, d1;

    // Reset with both requesters pending.
    req_valid = 2'b11;
    req_data0 = 8'b1101_1011;
    req_data1 = 8'b0000_1101;
    repeat (3) tick();
    #1;
    check("reset_outputs", 32'({req_ready, res_valid, res_id, res_count, busy}), 32'd0);
    n_rst = 1'b1;

    // Requester 0 wins the first tie; then requester 1 is served.
    start_word(2'b11, 8'b1101_1011, 8'b0000_1101, g, exp);
    finish_word(g, exp, 1'b0);
    start_word(2'b10, 8'h00, 8'b0000_1101, g, exp);
    finish_word(g, exp, 1'b0);
    start_word(2'b10, 8'h00, 8'hFF, g, exp);
    finish_word(g, exp, 1'b0);

    // No match may span two consecutive words.
    start_word(2'b01, 8'b0000_0110, 8'h00, g, exp);
    finish_word(g, exp, 1'b0);
    start_word(2'b01, 8'b1000_0000, 8'h00, g, exp);
    finish_word(g, exp, 1'b0);

    // Both held continuously: grants alternate.
    for (int i = 0; i < 4; i++) begin
      start_word(2'b11, DATA_W'($urandom), DATA_W'($urandom), g, exp);
      finish_word(g, exp, 1'b1);
    end
    req_valid = 2'b00;

    // Reset pulse in the fourth shift cycle aborts the word.
    d0 = 8'b0110_1101;
    d1 = 8'b1101_1010;
    start_word(2'b11, d0, d1, g, exp);
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("pre_abort", 32'({busy, res_valid}), 32'(2'b10));
      tick();
    end
    #1;
    n_rst = 1'b0;
    #1;
    check("abort_outputs", 32'({req_ready, res_valid, res_id, res_count, busy}), 32'd0);
    n_rst  = 1'b1;
    m_last = 1'b1;
    #1;
    start_word(2'b11, d0, d1, g, exp);
    finish_word(g, exp, 1'b0);

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 16; i++) begin
      v  = 2'($urandom_range(1, 3));
      d0 = DATA_W'($urandom);
      d1 = DATA_W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 2'b00;
        tick();
        #1;
        check("idle_gap", 32'({busy, res_valid, req_ready}), 32'd0);
      end
      start_word(v, d0, d1, g, exp);
      finish_word(g, exp, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/det_arbiter.md
# det_arbiter

Round-robin arbiter and sequencer that shares one serial "1101" pattern detector between two requesters. Each requester hands over a DATA_W-bit word with a valid/ready handshake. The block shifts the word MSB-first through the detector and counts overlapping matches. It then returns a one-cycle result pulse tagged with the requester id. The block sits between the word-level producers and the bit-serial detector datapath.

## Interface
- DATA_W, 8, word width in bits (≥4)
- CNT_W, $clog2(DATA_W+1), result count width (localparam, derived)

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- req_valid  in  2  bit r: requester r has a word pending; held until accepted
- req_data0  in  DATA_W  requester 0 word
- req_data1  in  DATA_W  requester 1 word
- req_ready  out  2  one-hot acceptance strobe; word captured on the edge ending this cycle
- res_valid  out  1  one-cycle result strobe
- res_id  out  1  requester whose word produced the result
- res_count  out  CNT_W  number of overlapping "1101" matches in the word
- busy  out  1  high in every state except IDLE

Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
- Controller FSM states: IDLE, SHIFT, FLUSH, DONE.
- IDLE:
  - If any req_valid is high, grant round-robin: the requester not granted last wins a tie. last_grant resets to 1, so requester 0 wins the first tie.
  - req_ready[g] is asserted combinationally in that cycle (Mealy output). The edge captures the word into the shift register, sets res_id=g, clears the match counter and synchronously clears the detector. FSM moves to SHIFT.
- SHIFT:
  - Lasts DATA_W cycles.
  - Shift register MSB drives detector input i; the register shifts left each cycle; the bit counter counts down.
- FLUSH: one cycle. It drains the detector's registered output for the last bit.
- DONE: res_valid=1 for one cycle with res_count and res_id stable, then IDLE.
- Match counting: the counter adds the detector's registered flag every cycle of SHIFT (except the first) and of FLUSH.
- Detector transitions (overlapping):
  - A: 1→B, 0→A
  - B: 1→C, 0→A
  - C: 0→D, 1→C
  - D: 1→B with flag=1, 0→A
  - The flag is registered into o, so a match appears one cycle after its last bit.
- Detector clear: returns state to A and zeroes o. Matches never span words.
- req_valid changes outside IDLE are ignored; requesters must hold data until req_ready.

## Timing
- Accept in cycle T. Bit k (k=0 is MSB) drives the detector in cycle T+1+k.
- Its match is counted in cycle T+2+k.
- FLUSH occurs in cycle T+DATA_W+1; res_valid in cycle T+DATA_W+2.
- The earliest next accept is cycle T+DATA_W+3. Throughput is one word per DATA_W+3 cycles.
- Reset values: req_ready=00, res_valid=0, res_id=0, res_count=0, busy=0, FSM=IDLE, detector=A/o=0, last_grant=1.
- Reset mid-operation aborts the word and emits no res_valid. Any pending req_valid is re-arbitrated after release.
- res_count holds its value outside DONE until the next DONE; only res_valid qualifies it.
- Counter width CNT_W cannot overflow for any DATA_W-bit word.

## Structure
- Shared package det_pkg holds:
  - typedef ctrl_state_t {IDLE, SHIFT, FLUSH, DONE}
  - typedef det_state_t {A, B, C, D}
  - constant PATTERN = 4'b1101
- One sub-module, seq1101_det (clk, n_rst, clr, i, o): the detector with synchronous clear and registered output.

## Test plan
- Reset with req_valid=11 held → all outputs 0 during reset; after release, req_ready=01 in the first cycle.
- req_data0=8'b1101_1011 → res_valid at T+10, res_id=0, res_count=2.
- req_data1=8'b0000_1101 → res_count=1 (the last-bit match is caught by FLUSH); 8'hFF → res_count=0.
- Cross-word isolation: word 8'b0000_0110 then 8'b1000_0000 from requester 0 → both res_count=0.
- req_valid=11 held continuously → grants alternate 0,1,0,1. Each res_id matches its grant; busy is low only in the accept cycles.
- n_rst pulsed low in SHIFT cycle T+4 → no res_valid for that word; after release, the same request is re-accepted and its full result is returned.
